// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, frame width and default bit timing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    // 8N1 frames carry eight data bits, LSB first.
    localparam int DATA_BITS = 8;

    // 9600 baud from a 100 MHz clock.
    localparam int DEFAULT_CLKS_PER_BIT = 10416;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for an asynchronous, idle-high serial line.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; q follows d continuously.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Both stages reset high so an idle line never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: recovers bytes from din and emits them with a one-cycle valid strobe.
// Latency: valid rises about 2 + HALF_BIT + 9*CLKS_PER_BIT cycles after the start-bit falling edge.
// Backpressure: none; valid/frame_err are single-cycle strobes and data holds until the next good frame.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);

    // Baud counter compare points: mid start bit and end of each full bit period.
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    logic                 rxs;

    rx_state_t            state,     state_nxt;
    logic [CW-1:0]        cnt,       cnt_nxt;
    logic [BW-1:0]        bit_idx,   bit_nxt;
    logic [DATA_BITS-1:0] shift,     shift_nxt;
    logic [DATA_BITS-1:0] data_nxt;
    logic                 valid_nxt;
    logic                 ferr_nxt;

    // din is asynchronous; only the synchronised copy is ever looked at.
    sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din),
        .q   (rxs)
    );

    // Frame state; reset aborts any frame in flight with no strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_idx   <= bit_nxt;
            shift     <= shift_nxt;
            data      <= data_nxt;
            valid     <= valid_nxt;
            frame_err <= ferr_nxt;
        end
    end

    // Next-state, bit timing and strobe generation.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        data_nxt  = data;
        valid_nxt = 1'b0;
        ferr_nxt  = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                bit_nxt = '0;
                if (!rxs) begin
                    state_nxt = START;
                end
            end

            // Re-check the line at mid start bit; a high line means the edge was a glitch.
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_nxt   = '0;
                    state_nxt = rxs ? IDLE : DATA;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            // Sampling is now phase-aligned to bit centres; shift right so the LSB lands in bit 0.
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    shift_nxt = {rxs, shift[DATA_BITS-1:1]};
                    if (bit_idx == BIT_LAST) begin
                        bit_nxt   = '0;
                        state_nxt = STOP;
                    end else begin
                        bit_nxt = bit_idx + 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            // Stop is checked at mid-bit, leaving half a bit to catch a back-to-back start.
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt = '0;
                    if (rxs) begin
                        data_nxt  = shift;
                        valid_nxt = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = BREAK;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            // A low line after a bad stop bit must not be mistaken for a new start.
            BREAK: begin
                cnt_nxt = '0;
                if (rxs) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                bit_nxt   = '0;
            end
        endcase
    end

    // Busy covers the whole frame, including glitch rejection and break recovery.
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
module tb_uart_byte_rx;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
    localparam int LAT  = 2 + HALF + 9 * CPB;

    typedef struct {
        logic [7:0] val;
        logic       stop;
        int         hold_low;
        int         exp_valid;
        int         exp_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    uart_byte_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int         checks;
    int         failures;
    int         valid_cnt;
    int         err_cnt;
    logic [7:0] last_good;
    logic       prev_valid;
    logic       prev_err;
    logic [7:0] exp_q[$];
    time        ft_q[$];
    time        vt_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard side: pops the expected byte whenever the DUT strobes valid.
    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (valid || frame_err) begin
                checks++;
                if (valid && frame_err) begin
                    failures++;
                    $display("FAIL strobe_exclusive valid=%0b frame_err=%0b required=not both", valid, frame_err);
                end
            end
            if (valid) begin
                valid_cnt++;
                vt_q.push_back($time);
                check("valid_one_cycle", prev_valid, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected data=%02h required=no valid", data);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_data", data, e);
                    last_good = e;
                end
            end
            if (frame_err) begin
                err_cnt++;
                check("err_one_cycle", prev_err, 0);
                check("err_data_hold", data, last_good);
            end
            prev_valid = valid;
            prev_err   = frame_err;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        ft_q.push_back($time);
        din = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            din = b[i];
            repeat (CPB) @(negedge clk);
        end
        din = stop;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic latency_check(input string name);
        time tf;
        time tv;
        int  lat;
        checks++;
        if (ft_q.size() == 0 || vt_q.size() == 0) begin
            failures++;
            $display("FAIL %s actual=no valid required=%0d cycles", name, LAT);
        end else begin
            tf  = ft_q.pop_front();
            tv  = vt_q.pop_front();
            lat = int'((tv - tf - 5) / 10);
            if (lat < LAT - 1 || lat > LAT + 1) begin
                failures++;
                $display("FAIL %s actual=%0d required=%0d+-1 cycles", name, lat, LAT);
            end
        end
    endtask

    initial begin
        vec_t vecs[6];
        int   v0;
        int   e0;
        int   n;
        int   gap;
        time  t1;
        time  t2;

        checks     = 0;
        failures   = 0;
        valid_cnt  = 0;
        err_cnt    = 0;
        last_good  = 8'h00;
        prev_valid = 1'b0;
        prev_err   = 1'b0;
        din        = 1'b1;
        rst        = 1'b1;

        vecs[0] = '{8'h63, 1'b1, 0,   1, 0};
        vecs[1] = '{8'h8E, 1'b1, 0,   1, 0};
        vecs[2] = '{8'h00, 1'b1, 0,   1, 0};
        vecs[3] = '{8'hFF, 1'b1, 0,   1, 0};
        vecs[4] = '{8'h3C, 1'b0, 100, 0, 1};
        vecs[5] = '{8'hC5, 1'b1, 0,   1, 0};

        fork
            monitor();
            begin
                #1000000;
                $display("FAIL watchdog actual=timeout required=finish");
                $fatal(1, "watchdog expired");
            end
        join_none

        repeat (3) @(negedge clk);
        check("rst_data", data, 8'h00);
        check("rst_valid", valid, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Single frames, including a bad stop bit followed by a held-low line.
        foreach (vecs[i]) begin
            check("data_hold", data, last_good);
            v0 = valid_cnt;
            e0 = err_cnt;
            if (vecs[i].stop) exp_q.push_back(vecs[i].val);
            send_frame(vecs[i].val, vecs[i].stop);
            if (vecs[i].hold_low > 0) begin
                repeat (vecs[i].hold_low) @(negedge clk);
                check("break_busy", busy, 1);
                check("break_no_valid", valid_cnt - v0, 0);
                din = 1'b1;
            end
            repeat (2 * CPB) @(negedge clk);
            check("row_valid", valid_cnt - v0, vecs[i].exp_valid);
            check("row_err", err_cnt - e0, vecs[i].exp_err);
            check("row_busy", busy, 0);
            if (vecs[i].exp_valid == 1) latency_check("row_latency");
            else void'(ft_q.pop_front());
        end

        // Back-to-back frames with a one-bit stop and no idle gap.
        ft_q.delete();
        vt_q.delete();
        v0 = valid_cnt;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hA3);
        send_frame(8'h55, 1'b1);
        send_frame(8'hA3, 1'b1);
        repeat (2 * CPB) @(negedge clk);
        check("b2b_valid", valid_cnt - v0, 2);
        checks++;
        if (vt_q.size() >= 2) begin
            t1  = vt_q.pop_front();
            t2  = vt_q.pop_front();
            gap = int'((t2 - t1) / 10);
            if (gap < 10 * CPB - 1 || gap > 10 * CPB + 1) begin
                failures++;
                $display("FAIL b2b_gap actual=%0d required=%0d+-1", gap, 10 * CPB);
            end
        end else begin
            failures++;
            $display("FAIL b2b_gap actual=%0d strobes required=2", vt_q.size());
        end
        ft_q.delete();
        vt_q.delete();

        // Three-cycle glitch: start detected, then rejected at mid start bit.
        v0 = valid_cnt;
        e0 = err_cnt;
        din = 1'b0;
        repeat (3) @(negedge clk);
        din = 1'b1;
        repeat (2) @(negedge clk);
        check("glitch_busy_hi", busy, 1);
        n = 0;
        while (busy && n < 7) begin
            @(negedge clk);
            n++;
        end
        check("glitch_busy_lo", busy, 0);
        repeat (2 * CPB) @(negedge clk);
        check("glitch_valid", valid_cnt - v0, 0);
        check("glitch_err", err_cnt - e0, 0);

        // Reset asserted asynchronously in the middle of data bit 4.
        din = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            din = 1'b0;
            repeat (CPB) @(negedge clk);
        end
        din = 1'b1;
        repeat (HALF) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_data", data, 8'h00);
        check("arst_valid", valid, 0);
        check("arst_ferr", frame_err, 0);
        last_good = 8'h00;
        @(negedge clk);
        din = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        v0 = valid_cnt;
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        repeat (2 * CPB) @(negedge clk);
        check("post_rst_valid", valid_cnt - v0, 1);
        check("post_rst_data", data, 8'h81);
        latency_check("post_rst_latency");

        check("sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
